uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 144 ++++++++++++++
 tb/tb_uart_rx_cfg.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with per-frame parity/stop configuration
// and error flags.
module uart_rx_cfg #(
    parameter int DATA_SIZE = 8,
    parameter int SYS_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int SAMPLE    = 16,
    parameter int BAUD_DVSR = SYS_FREQ / (SAMPLE * BAUD_RATE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rx_start,
    input  logic [1:0]           parity_mode,
    input  logic                 stop_bits,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 rx_done_tick,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);
    localparam int TW = $clog2(BAUD_DVSR + 1);
    localparam int SW = $clog2(SAMPLE);
    localparam int BW = $clog2(DATA_SIZE);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_n;
    logic                 rx_m, rx_q;
    logic [TW-1:0]        tcnt;
    logic                 s_tick, mid;
    logic [SW-1:0]        s_cnt, s_cnt_n;
    logic [BW-1:0]        b_cnt, b_cnt_n;
    logic [DATA_SIZE-1:0] sh, sh_n, data_n;
    logic                 pbit, pbit_n, fe, fe_n, st0, st0_n, sb, sb_n;
    logic [1:0]           pm, pm_n;
    logic                 perr_n, ferr_n, brk_n, done_n;

    assign s_tick = tcnt == TW'(BAUD_DVSR - 1);
    assign mid    = s_tick && s_cnt == SW'(SAMPLE - 1);
    assign busy   = state != IDLE;

    always_comb begin
        state_n = state;
        s_cnt_n = (s_tick && state != IDLE) ? s_cnt + SW'(1) : s_cnt;
        b_cnt_n = b_cnt;
        sh_n    = sh;
        pbit_n  = pbit;
        fe_n    = fe;
        st0_n   = st0;
        pm_n    = pm;
        sb_n    = sb;
        data_n  = data_out;
        perr_n  = parity_err;
        ferr_n  = frame_err;
        brk_n   = break_det;
        done_n  = 1'b0;
        case (state)
            IDLE: if (rx_start && !rx_q) begin
                state_n = START;
                s_cnt_n = '0;
                pm_n    = parity_mode;
                sb_n    = stop_bits;
            end
            START: if (s_tick && s_cnt == SW'(SAMPLE / 2 - 1)) begin
                state_n = rx_q ? IDLE : DATA;
                s_cnt_n = '0;
                b_cnt_n = '0;
            end
            DATA: if (mid) begin
                s_cnt_n = '0;
                sh_n    = {rx_q, sh[DATA_SIZE-1:1]};
                b_cnt_n = b_cnt + BW'(1);
                if (b_cnt == BW'(DATA_SIZE - 1)) begin
                    state_n = ^pm ? PARITY : STOP;
                    b_cnt_n = '0;
                    fe_n    = 1'b0;
                end
            end
            PARITY: if (mid) begin
                s_cnt_n = '0;
                pbit_n  = rx_q;
                state_n = STOP;
            end
            STOP: if (mid) begin
                s_cnt_n = '0;
                b_cnt_n = b_cnt + BW'(1);
                fe_n    = fe | ~rx_q;
                if (b_cnt == '0) st0_n = rx_q;
                // b_cnt counts stop bits here; sb selects one or two
                if (b_cnt == BW'(sb)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    data_n  = sh;
                    perr_n  = ^pm & (^sh ^ pbit ^ pm[1]);
                    ferr_n  = fe | ~rx_q;
                    brk_n   = ~|sh & ~(^pm & pbit) & ~(b_cnt == '0 ? rx_q : st0);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rx_m         <= 1'b1;
            rx_q         <= 1'b1;
            tcnt         <= '0;
            s_cnt        <= '0;
            b_cnt        <= '0;
            sh           <= '0;
            pbit         <= 1'b0;
            fe           <= 1'b0;
            st0          <= 1'b0;
            pm           <= '0;
            sb           <= 1'b0;
            data_out     <= '0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            break_det    <= 1'b0;
            rx_done_tick <= 1'b0;
        end else begin
            state        <= state_n;
            rx_m         <= rx;
            rx_q         <= rx_m;
            tcnt         <= s_tick ? '0 : tcnt + TW'(1);
            s_cnt        <= s_cnt_n;
            b_cnt        <= b_cnt_n;
            sh           <= sh_n;
            pbit         <= pbit_n;
            fe           <= fe_n;
            st0          <= st0_n;
            pm           <= pm_n;
            sb           <= sb_n;
            data_out     <= data_n;
            parity_err   <= perr_n;
            frame_err    <= ferr_n;
            break_det    <= brk_n;
            rx_done_tick <= done_n;
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed frames at default parameters (432 clks per bit).
module tb_uart_rx_cfg;
    localparam int BIT = 432;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rx_start = 1'b0;
    logic [1:0] parity_mode = 2'b00;
    logic       stop_bits = 1'b0;
    logic [7:0] data_out;
    logic       rx_done_tick, parity_err, frame_err, break_det, busy;
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         n;
    logic [7:0] d;

    uart_rx_cfg dut (
        .clk(clk), .reset(reset), .rx(rx), .rx_start(rx_start),
        .parity_mode(parity_mode), .stop_bits(stop_bits), .data_out(data_out),
        .rx_done_tick(rx_done_tick), .parity_err(parity_err), .frame_err(frame_err),
        .break_det(break_det), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (rx_done_tick === 1'b1) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic b, input int len);
        rx = b;
        repeat (len) @(negedge clk);
    endtask

    // pb/st2 < 0 means that bit is absent; a low second stop bit is kept short so
    // the line is already high when the receiver next looks for a start bit
    task automatic frame(input logic [7:0] v, input int pb, input logic st1, input int st2);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(v[i], BIT);
        if (pb >= 0) drive(pb[0], BIT);
        drive(st1, BIT);
        if (st2 == 0) begin
            drive(1'b0, 300);
            drive(1'b1, BIT - 300);
        end else if (st2 > 0) drive(1'b1, BIT);
        drive(1'b1, BIT);
    endtask

    initial begin
        repeat (27) begin
            @(negedge clk);
            chk("reset_outs", {data_out, rx_done_tick, parity_err, frame_err, break_det, busy}, 0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        rx_start = 1'b1;
        n = done_cnt;
        frame(8'hCD, -1, 1'b1, -1);
        chk("cd_done", done_cnt - n, 1);
        chk("cd_data", data_out, 8'hCD);
        chk("cd_flags", {parity_err, frame_err, break_det}, 0);

        parity_mode = 2'b01;
        n = done_cnt;
        frame(8'hCD, 0, 1'b1, -1);
        chk("even_p0_done", done_cnt - n, 1);
        chk("even_p0_perr", parity_err, 1);
        chk("even_p0_data", data_out, 8'hCD);
        frame(8'hCD, 1, 1'b1, -1);
        chk("even_p1_perr", parity_err, 0);
        chk("even_p1_done", done_cnt - n, 2);

        // odd frame with rx_start and config disturbed mid-frame
        parity_mode = 2'b10;
        d = 8'hCD;
        n = done_cnt;
        drive(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(d[i], BIT);
        rx_start = 1'b0;
        parity_mode = 2'b01;
        stop_bits = 1'b1;
        for (int i = 4; i < 8; i++) drive(d[i], BIT);
        drive(1'b0, BIT);
        drive(1'b1, BIT);
        drive(1'b1, BIT);
        chk("odd_p0_done", done_cnt - n, 1);
        chk("odd_p0_perr", parity_err, 0);
        chk("odd_p0_ferr", frame_err, 0);

        rx_start = 1'b1;
        parity_mode = 2'b00;
        stop_bits = 1'b1;
        n = done_cnt;
        frame(8'h3C, -1, 1'b1, 0);
        chk("stop2_done", done_cnt - n, 1);
        chk("stop2_data", data_out, 8'h3C);
        chk("stop2_flags", {parity_err, frame_err, break_det}, 3'b010);
        frame(8'h00, -1, 1'b0, 1);
        chk("brk_done", done_cnt - n, 2);
        chk("brk_data", data_out, 8'h00);
        chk("brk_flags", {parity_err, frame_err, break_det}, 3'b011);

        stop_bits = 1'b0;
        n = done_cnt;
        rx = 1'b0;
        repeat (50) @(negedge clk);
        chk("glitch_busy_hi", busy, 1);
        repeat (50) @(negedge clk);
        rx = 1'b1;
        repeat (216) @(negedge clk);
        chk("glitch_busy_lo", busy, 0);
        chk("glitch_done", done_cnt - n, 0);
        chk("glitch_hold", {data_out, frame_err, break_det}, {8'h00, 2'b11});

        rx_start = 1'b0;
        d = 8'h81;
        drive(1'b0, BIT);
        chk("nostart_busy", busy, 0);
        for (int i = 0; i < 8; i++) drive(d[i], BIT);
        drive(1'b1, 2 * BIT);
        chk("nostart_done", done_cnt - n, 0);
        chk("nostart_data", data_out, 8'h00);

        rx_start = 1'b1;
        d = 8'h5A;
        drive(1'b0, BIT);
        for (int i = 0; i < 3; i++) drive(d[i], BIT);
        drive(d[3], 216);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_outs", {data_out, rx_done_tick, parity_err, frame_err, break_det, busy}, 0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (BIT) @(negedge clk);
        chk("midrst_done", done_cnt - n, 0);
        chk("midrst_after", {data_out, parity_err, frame_err, break_det, busy}, 0);
        frame(8'h5A, -1, 1'b1, -1);
        chk("5a_done", done_cnt - n, 1);
        chk("5a_data", data_out, 8'h5A);
        chk("5a_flags", {parity_err, frame_err, break_det}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
